// File: rtl/sr_ff_bank.sv
// Bank of run-time-mode flip-flops (SR/JK/D/T) with sticky per-bit capture
// of the S=R=1 condition in SR mode.

module sr_ff_cell #(
    parameter logic RST_VAL = 1'b0,
    parameter int   POLICY  = 0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [1:0] mode_i,
    input  logic       s_i,
    input  logic       r_i,
    input  logic       clr_err_i,
    output logic       q_o,
    output logic       err_bit_o,
    output logic       err_bit_d_o,
    output logic       chg_o
);
    localparam logic [1:0] M_SR = 2'b00, M_JK = 2'b01, M_D = 2'b10, M_T = 2'b11;

    logic q_q, q_d, err_q, err_d, viol;

    always_comb begin
        q_d = q_q;
        if (en_i) begin
            unique case (mode_i)
                M_SR: begin
                    unique case ({s_i, r_i})
                        2'b10:   q_d = 1'b1;
                        2'b01:   q_d = 1'b0;
                        2'b11: begin
                            if (POLICY == 1)      q_d = 1'b1;
                            else if (POLICY == 2) q_d = 1'b0;
                            else if (POLICY == 3) q_d = ~q_q;
                            else                  q_d = q_q;
                        end
                        default: q_d = q_q;
                    endcase
                end
                M_JK: begin
                    unique case ({s_i, r_i})
                        2'b10:   q_d = 1'b1;
                        2'b01:   q_d = 1'b0;
                        2'b11:   q_d = ~q_q;
                        default: q_d = q_q;
                    endcase
                end
                M_D:     q_d = s_i;
                M_T:     q_d = s_i ? ~q_q : q_q;
                default: q_d = q_q;
            endcase
        end
    end

    // A fresh violation wins over a same-edge clear.
    assign viol  = en_i && (mode_i == M_SR) && s_i && r_i;
    assign err_d = (clr_err_i ? 1'b0 : err_q) | viol;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q   <= RST_VAL;
            err_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            err_q <= err_d;
        end
    end

    assign q_o         = q_q;
    assign err_bit_o   = err_q;
    assign err_bit_d_o = err_d;
    assign chg_o       = q_d ^ q_q;
endmodule

module sr_ff_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int               SR_POLICY = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] s_i,
    input  logic [WIDTH-1:0] r_i,
    input  logic             clr_err_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] qn_o,
    output logic             err_o,
    output logic [WIDTH-1:0] err_bits_o,
    output logic             chg_o
);
    logic [WIDTH-1:0] chg_bit, err_bits_d;
    logic             err_q, chg_q;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        sr_ff_cell #(.RST_VAL(RESET_VAL[g]), .POLICY(SR_POLICY)) u_cell (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .en_i        (en_i),
            .mode_i      (mode_i),
            .s_i         (s_i[g]),
            .r_i         (r_i[g]),
            .clr_err_i   (clr_err_i),
            .q_o         (q_o[g]),
            .err_bit_o   (err_bits_o[g]),
            .err_bit_d_o (err_bits_d[g]),
            .chg_o       (chg_bit[g])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
            chg_q <= 1'b0;
        end else begin
            err_q <= |err_bits_d;
            chg_q <= |chg_bit;
        end
    end

    assign qn_o  = ~q_o;
    assign err_o = err_q;
    assign chg_o = chg_q;
endmodule

// File: tb/tb_sr_ff_bank.sv
// Directed bench: four WIDTH=4 banks, one per SR policy, checked every cycle
// against a behavioural model plus hand-computed literals.

module tb_sr_ff_bank;
    localparam logic [1:0] SR = 2'b00, JK = 2'b01, D = 2'b10, T = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, clr = 1'b0;
    logic [1:0] mode = SR;
    logic [3:0] s = '0, r = '0;

    logic [3:0] dq[4], dqn[4], dbits[4];
    logic       derr[4], dchg[4];

    logic [3:0] mq[4], mbits[4];
    logic       merr[4], mchg[4];

    int vectors = 0, miscompares = 0;
    bit cmp_on = 1'b0;

    always #10 clk = ~clk;

    for (genvar p = 0; p < 4; p++) begin : g_dut
        sr_ff_bank #(.WIDTH(4), .RESET_VAL(4'b0000), .SR_POLICY(p)) u_dut (
            .clk_i      (clk),
            .rst_ni     (rst_n),
            .en_i       (en),
            .mode_i     (mode),
            .s_i        (s),
            .r_i        (r),
            .clr_err_i  (clr),
            .q_o        (dq[p]),
            .qn_o       (dqn[p]),
            .err_o      (derr[p]),
            .err_bits_o (dbits[p]),
            .chg_o      (dchg[p])
        );
    end

    // Next state of a 4-bit bank straight from the mode truth tables.
    function automatic logic [3:0] nxt(input logic [3:0] q, input logic [3:0] si,
                                       input logic [3:0] ri, input logic [1:0] m,
                                       input logic e, input int pol);
        logic [3:0] n;
        n = q;
        if (e) begin
            for (int i = 0; i < 4; i++) begin
                if (m == D)       n[i] = si[i];
                else if (m == T)  n[i] = q[i] ^ si[i];
                else if (si[i] && !ri[i]) n[i] = 1'b1;
                else if (!si[i] && ri[i]) n[i] = 1'b0;
                else if (si[i] && ri[i]) begin
                    if (m == JK || pol == 3) n[i] = ~q[i];
                    else if (pol == 1)       n[i] = 1'b1;
                    else if (pol == 2)       n[i] = 1'b0;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 4; p++) begin
                mq[p] <= 4'b0000; mbits[p] <= 4'b0000; merr[p] <= 1'b0; mchg[p] <= 1'b0;
            end
        end else begin
            for (int p = 0; p < 4; p++) begin
                logic [3:0] n, v;
                n = nxt(mq[p], s, r, mode, en, p);
                v = (en && mode == SR) ? (s & r) : 4'b0000;
                mchg[p]  <= (n != mq[p]);
                mq[p]    <= n;
                mbits[p] <= (clr ? 4'b0000 : mbits[p]) | v;
                merr[p]  <= (clr ? 1'b0 : merr[p]) | (|v);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            for (int p = 0; p < 4; p++) begin
                chk($sformatf("q[%0d]", p),    {28'd0, dq[p]},    {28'd0, mq[p]});
                chk($sformatf("qn[%0d]", p),   {28'd0, dqn[p]},   {28'd0, ~mq[p]});
                chk($sformatf("err[%0d]", p),  {31'd0, derr[p]},  {31'd0, merr[p]});
                chk($sformatf("bits[%0d]", p), {28'd0, dbits[p]}, {28'd0, mbits[p]});
                chk($sformatf("chg[%0d]", p),  {31'd0, dchg[p]},  {31'd0, mchg[p]});
            end
        end
    end

    // Drive one edge's inputs, then land 1 time unit after that edge.
    task automatic cyc(input logic [1:0] m, input logic [3:0] sv, input logic [3:0] rv,
                       input logic e = 1'b1, input logic c = 1'b0);
        mode = m; s = sv; r = rv; en = e; clr = c;
        @(posedge clk); #1;
    endtask

    initial begin
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b1;
        #1;
        chk("rst_q",   {28'd0, dq[0]},  32'h0);
        chk("rst_qn",  {28'd0, dqn[0]}, 32'hF);
        chk("rst_err", {31'd0, derr[0]}, 32'h0);
        chk("rst_chg", {31'd0, dchg[0]}, 32'h0);
        cmp_on = 1'b1;
        @(posedge clk); #1;

        // Mid-cycle asynchronous reset from Q=1010.
        cyc(D, 4'b1010, 4'b0000);
        chk("pre_rst_q", {28'd0, dq[0]}, 32'hA);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_q",   {28'd0, dq[0]},  32'h0);
        chk("arst_qn",  {28'd0, dqn[0]}, 32'hF);
        chk("arst_chg", {31'd0, dchg[0]}, 32'h0);
        chk("arst_err", {31'd0, derr[0]}, 32'h0);
        #1 rst_n = 1'b1;

        cyc(SR, 4'b0011, 4'b0000);
        chk("sr_set", {28'd0, dq[0]}, 32'h3);
        cyc(SR, 4'b0000, 4'b0001);
        chk("sr_clr", {28'd0, dq[0]}, 32'h2);
        cyc(SR, 4'b0110, 4'b0110);
        chk("sr_hold",  {28'd0, dq[0]},    32'h2);
        chk("sr_err",   {31'd0, derr[0]},  32'h1);
        chk("sr_bits",  {28'd0, dbits[0]}, 32'h6);

        cyc(D, 4'b0101, 4'b1111, 1'b1, 1'b1);
        chk("d_noerr", {31'd0, derr[0]}, 32'h0);
        cyc(SR, 4'b1111, 4'b1111);
        chk("pol0", {28'd0, dq[0]}, 32'h5);
        chk("pol1", {28'd0, dq[1]}, 32'hF);
        chk("pol2", {28'd0, dq[2]}, 32'h0);
        chk("pol3", {28'd0, dq[3]}, 32'hA);
        for (int p = 0; p < 4; p++) chk($sformatf("pol_err%0d", p), {31'd0, derr[p]}, 32'h1);

        cyc(D, 4'b0101, 4'b0000, 1'b1, 1'b1);
        cyc(JK, 4'b1111, 4'b1111);
        chk("jk_tog", {28'd0, dq[0]},   32'hA);
        chk("jk_err", {31'd0, derr[0]}, 32'h0);
        cyc(D, 4'b1001, 4'b0110);
        chk("d_load", {28'd0, dq[0]}, 32'h9);
        cyc(T, 4'b0011, 4'b1111);
        chk("t_tog", {28'd0, dq[0]}, 32'hA);

        for (int k = 0; k < 3; k++) begin
            cyc(D, 4'b1111, 4'b0000, 1'b0);
            chk("en0_q",   {28'd0, dq[0]},   32'hA);
            chk("en0_chg", {31'd0, dchg[0]}, 32'h0);
        end
        cyc(SR, 4'b1111, 4'b1111, 1'b0);
        chk("en0_noerr", {31'd0, derr[0]}, 32'h0);
        cyc(D, 4'b1111, 4'b0000);
        chk("en1_q",   {28'd0, dq[0]},   32'hF);
        chk("en1_chg", {31'd0, dchg[0]}, 32'h1);
        cyc(D, 4'b1111, 4'b0000);
        chk("chg_pulse", {31'd0, dchg[0]}, 32'h0);

        cyc(SR, 4'b0001, 4'b0001);
        chk("e6_set", {28'd0, dbits[0]}, 32'h1);
        cyc(SR, 4'b0000, 4'b0000, 1'b1, 1'b1);
        chk("clr_err",  {31'd0, derr[0]},  32'h0);
        chk("clr_bits", {28'd0, dbits[0]}, 32'h0);
        cyc(SR, 4'b0001, 4'b0001);
        cyc(SR, 4'b1000, 4'b1000, 1'b1, 1'b1);
        chk("clrnew_err",  {31'd0, derr[0]},  32'h1);
        chk("clrnew_bits", {28'd0, dbits[0]}, 32'h8);

        cyc(T, 4'b0110, 4'b0000);
        cyc(JK, 4'b1010, 4'b0101);
        @(negedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
